// File: rtl/dbus_uncached_responder.sv
// rtl/dbus_uncached_responder.sv - uncached DBus responder bridging CPU requests to an in-order memory port
module dbus_uncached_responder #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req,
    input  logic                     wr,
    input  logic                     iscache,
    input  logic [19:0]              tag,
    input  logic [7:0]               index,
    input  logic [3:0]               offset,
    input  logic [3:0]               wstrb,
    input  logic [1:0]               size,
    input  logic [31:0]              wdata,
    output logic                     addr_ok,
    output logic                     data_ok,
    output logic [31:0]              rdata,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [31:0]              mem_addr,
    output logic [1:0]               mem_size,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_unexpected
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] local_q;
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic full, empty, head_local, local_pend;
    logic push, pop, pop_mem, pop_local, stray;

    always_comb begin
        full       = (count == CW'(DEPTH));
        empty      = (count == '0);
        head_local = local_q[rd_ptr];
        local_pend = |(local_q & vld_q);

        mem_req    = req & ~iscache & ~full & ~local_pend;
        mem_wr     = wr;
        mem_addr   = {tag, index, offset};
        mem_size   = size;
        mem_wstrb  = wr ? wstrb : 4'b0000;
        mem_wdata  = wdata;

        // Cache ops only go in on an empty FIFO so they never overtake memory traffic.
        addr_ok    = iscache ? (req & empty) : (mem_req & mem_gnt);

        push       = addr_ok;
        pop_mem    = ~empty & ~head_local & mem_rvalid;
        pop_local  = ~empty & head_local;
        pop        = pop_mem | pop_local;
        stray      = mem_rvalid & (empty | head_local);
    end

    assign outstanding = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            local_q        <= '0;
            vld_q          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_ok        <= 1'b0;
            rdata          <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (push) begin
                local_q[wr_ptr] <= iscache;
                vld_q[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            data_ok <= pop;
            rdata   <= pop_mem ? mem_rdata : 32'h0;
            if (stray) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule
